// File: rtl/msrv32_pc_ctrl.sv
// rtl/msrv32_pc_ctrl.sv - PC mux sequencer: boot hold-off, trap entry, mret return, stall handling
// Optional stall counter is built only when PC_CTRL_STALL_CNT_EN is defined.
module msrv32_pc_ctrl #(
  parameter int BOOT_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ahb_ready_in,
  input  logic        trap_req_in,
  input  logic        misaligned_instr_logic_in,
  input  logic        mret_in,
  output logic [1:0]  pc_src_out,
  output logic        pc_update_out,
  output logic        flush_out,
  output logic        trap_taken_out,
  output logic [31:0] stall_count_out
);

  localparam logic [1:0] BOOT = 2'b00;
  localparam logic [1:0] RET  = 2'b01;
  localparam logic [1:0] TRAP = 2'b10;
  localparam logic [1:0] RUN  = 2'b11;

  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] boot_cnt, boot_cnt_nxt;
  logic          trap_pend, trap_pend_nxt;
  logic          mret_pend, mret_pend_nxt;
  logic          trap_ev, mret_ev;

  assign trap_ev = trap_req_in | misaligned_instr_logic_in | trap_pend;
  assign mret_ev = mret_in | mret_pend;

  always_comb begin
    state_nxt     = state;
    boot_cnt_nxt  = boot_cnt;
    trap_pend_nxt = trap_pend;
    mret_pend_nxt = mret_pend;
    case (state)
      BOOT: begin
        if (ahb_ready_in) begin
          if (boot_cnt == BOOT_LAST) begin
            state_nxt    = RUN;
            boot_cnt_nxt = '0;
          end else begin
            boot_cnt_nxt = boot_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        if (ahb_ready_in) begin
          // A coincident mret is dropped: the trap overwrites epc anyway.
          if (trap_ev || mret_ev) begin
            state_nxt     = trap_ev ? TRAP : RET;
            trap_pend_nxt = 1'b0;
            mret_pend_nxt = 1'b0;
          end
        end else begin
          trap_pend_nxt = trap_pend | misaligned_instr_logic_in;
          mret_pend_nxt = mret_pend | mret_in;
        end
      end
      TRAP: begin
        if (ahb_ready_in) state_nxt = RUN;
      end
      RET: begin
        trap_pend_nxt = trap_pend | trap_req_in;
        if (ahb_ready_in) state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= BOOT;
      boot_cnt  <= '0;
      trap_pend <= 1'b0;
      mret_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      boot_cnt  <= boot_cnt_nxt;
      trap_pend <= trap_pend_nxt;
      mret_pend <= mret_pend_nxt;
    end
  end

  assign pc_src_out     = state;
  assign flush_out      = (state != RUN);
  assign pc_update_out  = ahb_ready_in & ~rst_in;
  assign trap_taken_out = (state == TRAP) & ahb_ready_in;

`ifdef PC_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cnt <= 32'h0;
    end else if (state == RUN && !ahb_ready_in) begin
      stall_cnt <= stall_cnt + 32'h1;
    end
  end

  assign stall_count_out = stall_cnt;
`else
  assign stall_count_out = 32'h0;
`endif

endmodule
